// File: rtl/qcs_dyn_pre_out_tx_if.sv
// Push, control and sample-output bundle for qcs_dyn_pre_out_tx.
// master: the side that pushes samples and issues commands; slave: the transmitter.
interface qcs_dyn_pre_out_tx_if #(
  parameter int unsigned DW   = 16,
  parameter int unsigned LW   = 12,
  parameter int unsigned DIVW = 4
);
  logic            wr_en;
  logic [DW-1:0]   wr_i_0;
  logic [DW-1:0]   wr_q_0;
  logic [DW-1:0]   wr_i_1;
  logic [DW-1:0]   wr_q_1;
  logic            full;
  logic            start;
  logic            stop;
  logic [LW-1:0]   pkt_len;
  logic [DIVW-1:0] div;
  logic            nhtp_re;
  logic [DW-1:0]   data_i_0;
  logic [DW-1:0]   data_q_0;
  logic [DW-1:0]   data_i_1;
  logic [DW-1:0]   data_q_1;
  logic            busy;
  logic            done;
  logic            underflow;
  logic            overflow;

  modport master (
    output wr_en, wr_i_0, wr_q_0, wr_i_1, wr_q_1, start, stop, pkt_len, div,
    input  full, nhtp_re, data_i_0, data_q_0, data_i_1, data_q_1,
           busy, done, underflow, overflow
  );

  modport slave (
    input  wr_en, wr_i_0, wr_q_0, wr_i_1, wr_q_1, start, stop, pkt_len, div,
    output full, nhtp_re, data_i_0, data_q_0, data_i_1, data_q_1,
           busy, done, underflow, overflow
  );
endinterface

// File: rtl/qcs_dyn_pre_out_tx.sv
// Dynamic preamble output transmitter: FIFO-buffered dual-stream I/Q pairs
// emitted on nhtp_re at one slot every div+1 cycles.
// Optional macro QCS_DYN_PRE_OUT_TX_ZERO_FILL_EN: an attempt on an empty FIFO
// emits an all-zero pair instead of stalling, keeping packet duration fixed.
module qcs_dyn_pre_out_tx #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned LW    = 12,
  parameter int unsigned DIVW  = 4
) (
  input logic               clk,
  input logic               reset_n,
  qcs_dyn_pre_out_tx_if.slave bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = 4 * DW;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   cnt_q;
  logic [LW-1:0]   len_q, len_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [DIVW-1:0] slot_q, slot_d;
  logic [PW-1:0]   data_q, data_d;
  logic            nhtp_q, nhtp_d;
  logic            done_q, done_d;
  logic            pend_q, pend_d;
  logic            under_q, under_d;
  logic            over_q, over_d;
  logic            empty, full, push, pop, emit;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

  // Sample storage; no reset needed, validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= {bus.wr_i_0, bus.wr_q_0, bus.wr_i_1, bus.wr_q_1};
  end

  // FIFO pointers and occupancy; stop flushes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (bus.stop) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      div_q   <= '0;
      slot_q  <= '0;
      data_q  <= '0;
      nhtp_q  <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
      under_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      div_q   <= div_d;
      slot_q  <= slot_d;
      data_q  <= data_d;
      nhtp_q  <= nhtp_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
      under_q <= under_d;
      over_q  <= over_d;
    end
  end

  // Next-state: start/stop handling, slot pacing, emission and FIFO accept.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    div_d   = div_q;
    slot_d  = slot_q;
    data_d  = data_q;
    nhtp_d  = 1'b0;
    done_d  = pend_q;
    pend_d  = 1'b0;
    under_d = under_q;
    over_d  = over_q;
    push    = 1'b0;
    pop     = 1'b0;
    emit    = 1'b0;
    if (bus.stop) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.pkt_len != '0) begin
              state_d = RUN;
              len_d   = bus.pkt_len;
              div_d   = bus.div;
              slot_d  = '0;
              under_d = 1'b0;
              over_d  = 1'b0;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        RUN: begin
          if (slot_q == div_q) begin
            if (!empty) begin
              pop    = 1'b1;
              emit   = 1'b1;
              data_d = mem[rd_q];
            end else begin
              under_d = 1'b1;
`ifdef QCS_DYN_PRE_OUT_TX_ZERO_FILL_EN
              emit   = 1'b1;
              data_d = '0;
`endif
            end
            if (emit) begin
              nhtp_d = 1'b1;
              slot_d = '0;
              len_d  = len_q - LW'(1);
              if (len_q == LW'(1)) begin
                state_d = IDLE;
                pend_d  = 1'b1;
              end
            end
          end else begin
            slot_d = slot_q + DIVW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
      push = bus.wr_en && (!full || pop);
      if (bus.wr_en && full && !pop) over_d = 1'b1;
    end
  end

  assign bus.full      = full;
  assign bus.nhtp_re   = nhtp_q;
  assign bus.data_i_0  = data_q[PW-1 -: DW];
  assign bus.data_q_0  = data_q[PW-DW-1 -: DW];
  assign bus.data_i_1  = data_q[2*DW-1 -: DW];
  assign bus.data_q_1  = data_q[DW-1:0];
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = done_q;
  assign bus.underflow = under_q;
  assign bus.overflow  = over_q;
endmodule

// File: tb/tb_qcs_dyn_pre_out_tx.sv
// Bench for qcs_dyn_pre_out_tx: directed scenarios with random data, strobe
// timing and payload predicted from the pacing/stall rules.
module tb_qcs_dyn_pre_out_tx;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LW    = 12;
  localparam int unsigned DIVW  = 4;
`ifdef QCS_DYN_PRE_OUT_TX_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  typedef struct { logic [63:0] d; int avail; } ent_t;
  typedef struct { int cyc; logic [63:0] d; } obs_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  qcs_dyn_pre_out_tx_if #(.DW(DW), .LW(LW), .DIVW(DIVW)) bus ();
  qcs_dyn_pre_out_tx #(.DW(DW), .DEPTH(DEPTH), .LW(LW), .DIVW(DIVW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  ent_t mq[$];
  obs_t obs[$];
  obs_t exp_e[$];
  int   dones[$];
  int   exp_done;
  bit   exp_uf;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Cycle label advances on each edge; outputs sampled 1 time unit later.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (bus.nhtp_re === 1'b1)
      obs.push_back('{cyc, {bus.data_i_0, bus.data_q_0, bus.data_i_1, bus.data_q_1}});
    if (bus.done === 1'b1) dones.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [63:0] d);
    bus.wr_en  = 1'b1;
    bus.wr_i_0 = d[63:48];
    bus.wr_q_0 = d[47:32];
    bus.wr_i_1 = d[31:16];
    bus.wr_q_1 = d[15:0];
    if (mq.size() < DEPTH) mq.push_back('{d, cyc + 1});
    step(1);
    bus.wr_en = 1'b0;
  endtask

  task automatic start(input int len, input int dv, output int s);
    bus.start   = 1'b1;
    bus.pkt_len = LW'(len);
    bus.div     = DIVW'(dv);
    s = cyc;
    step(1);
    bus.start = 1'b0;
    chk("busy_after_start", 64'(bus.busy), 64'(len != 0));
  endtask

  task automatic flush();
    bus.stop = 1'b1;
    step(1);
    bus.stop = 1'b0;
    step(1);
    mq.delete();
    obs.delete();
    dones.delete();
  endtask

  // Slot schedule: attempt every div+1 cycles; an entry is usable once its
  // availability cycle is reached; otherwise stall or zero-fill.
  task automatic predict(input int s, input int dv, input int len);
    int t;
    int idx;
    t = s + 1 + dv;
    idx = 0;
    exp_e.delete();
    exp_uf = 1'b0;
    for (int k = 0; k < len; k++) begin
      if (idx < mq.size() && mq[idx].avail <= t) begin
        exp_e.push_back('{t + 1, mq[idx].d});
        idx++;
      end else begin
        exp_uf = 1'b1;
        if (ZF) begin
          exp_e.push_back('{t + 1, 64'h0});
        end else if (idx < mq.size()) begin
          t = mq[idx].avail;
          exp_e.push_back('{t + 1, mq[idx].d});
          idx++;
        end
      end
      t = t + dv + 1;
    end
    exp_done = (exp_e.size() > 0) ? exp_e[exp_e.size() - 1].cyc + 1 : cyc + 4;
  endtask

  task automatic run_and_compare(input string tag, input int s, input int dv, input int len);
    int n;
    predict(s, dv, len);
    while (cyc < exp_done + 2) step(1);
    chk({tag, "_count"}, 64'(obs.size()), 64'(exp_e.size()));
    n = (obs.size() < exp_e.size()) ? obs.size() : exp_e.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_cyc"}, 64'(obs[i].cyc), 64'(exp_e[i].cyc));
      chk({tag, "_data"}, obs[i].d, exp_e[i].d);
    end
    chk({tag, "_ndone"}, 64'(dones.size()), 64'd1);
    if (dones.size() > 0) chk({tag, "_done_cyc"}, 64'(dones[0]), 64'(exp_done));
    chk({tag, "_underflow"}, 64'(bus.underflow), 64'(exp_uf));
    chk({tag, "_overflow"}, 64'(bus.overflow), 64'd0);
    chk({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
    chk({tag, "_nhtp_end"}, 64'(bus.nhtp_re), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_nhtp"}, 64'(bus.nhtp_re), 64'd0);
    chk({tag, "_data"}, {bus.data_i_0, bus.data_q_0, bus.data_i_1, bus.data_q_1}, 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
    chk({tag, "_uf"}, 64'(bus.underflow), 64'd0);
    chk({tag, "_of"}, 64'(bus.overflow), 64'd0);
    chk({tag, "_full"}, 64'(bus.full), 64'd0);
  endtask

  initial begin
    int s;
    int len;
    int dv;
    int guard;
    bus.wr_en = 1'b0; bus.wr_i_0 = '0; bus.wr_q_0 = '0; bus.wr_i_1 = '0; bus.wr_q_1 = '0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.pkt_len = '0; bus.div = '0;

    // Reset values
    step(2);
    chk_all_zero("reset");
    reset_n = 1'b1;
    step(2);

    // Four known pairs, back-to-back strobes
    for (int i = 1; i <= 4; i++)
      push({16'(i), 16'(i + 'h100), 16'(i + 'h200), 16'(i + 'h300)});
    step(1);
    start(4, 0, s);
    run_and_compare("tp_b2b", s, 0, 4);
    if (obs.size() > 0) chk("tp_b2b_first", 64'(obs[0].cyc), 64'(s + 2));
    if (dones.size() > 0) chk("tp_b2b_done", 64'(dones[0]), 64'(s + 6));
    flush();

    // Paced packet div=2 len=3
    for (int i = 0; i < 3; i++) push({$urandom, $urandom});
    start(3, 2, s);
    run_and_compare("div2", s, 2, 3);
    flush();

    // Random packets
    for (int r = 0; r < 4; r++) begin
      len = int'($urandom_range(1, 8));
      dv  = int'($urandom_range(0, 3));
      for (int i = 0; i < len; i++) push({$urandom, $urandom});
      step(int'($urandom_range(0, 2)));
      start(len, dv, s);
      run_and_compare("rand", s, dv, len);
      flush();
    end

    // Zero-length start
    start(0, 1, s);
    step(3);
    chk("zlen_ndone", 64'(dones.size()), 64'd1);
    if (dones.size() > 0) chk("zlen_done_cyc", 64'(dones[0]), 64'(s + 1));
    chk("zlen_nstrobe", 64'(obs.size()), 64'd0);
    flush();

    // Underflow: one pair held, more arrive late
    push({$urandom, $urandom});
    start(3, 1, s);
    while (cyc < s + 5) step(1);
    push({$urandom, $urandom});
    push({$urandom, $urandom});
    run_and_compare("uflow", s, 1, 3);
    flush();

    // Overflow: 17 pushes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) push({$urandom, $urandom});
    chk("ovf_flag", 64'(bus.overflow), 64'd1);
    chk("ovf_full", 64'(bus.full), 64'd1);
    start(16, 0, s);
    run_and_compare("ovf_drain", s, 0, 16);
    flush();

    // Stop mid-packet after two strobes
    for (int i = 0; i < 8; i++) push({$urandom, $urandom});
    dv = int'($urandom_range(0, 2));
    start(8, dv, s);
    guard = 0;
    while (obs.size() < 2 && guard < 60) begin
      step(1);
      guard++;
    end
    chk("stop_reach2", 64'(obs.size() >= 2), 64'd1);
    bus.stop = 1'b1;
    step(1);
    bus.stop = 1'b0;
    chk("stop_busy", 64'(bus.busy), 64'd0);
    step(10);
    chk("stop_nstrobe", 64'(obs.size()), 64'd2);
    chk("stop_ndone", 64'(dones.size()), 64'd0);
    chk("stop_full", 64'(bus.full), 64'd0);
    mq.delete(); obs.delete(); dones.delete();
    push({$urandom, $urandom});
    start(1, 0, s);
    run_and_compare("post_stop", s, 0, 1);
    flush();

    // Asynchronous reset mid-packet
    for (int i = 0; i < 6; i++) push({$urandom, $urandom});
    start(6, 0, s);
    step(3);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("rst_mid");
    step(1);
    reset_n = 1'b1;
    mq.delete(); obs.delete(); dones.delete();
    step(4);
    chk("rst_mid_ndone", 64'(dones.size()), 64'd0);
    chk("rst_mid_nstrobe", 64'(obs.size()), 64'd0);
    len = int'($urandom_range(1, 6));
    dv  = int'($urandom_range(0, 3));
    for (int i = 0; i < len; i++) push({$urandom, $urandom});
    start(len, dv, s);
    run_and_compare("post_rst", s, dv, len);
    flush();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
